// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: halts the CPU and copies one 256-byte page to PPU OAMDATA, one get/put pair per byte.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cycle_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_r_nw,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_r_nw,
    input  logic [7:0]  bus_din,
    output logic        dma_done
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
    state_t     state_q, state_d;
    logic [7:0] page_q, page_d, idx_q, idx_d, data_q, data_d;
    logic       par_q, par_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        done_d  = 1'b0;
        if (cpu_cycle_en) begin
            par_d = ~par_q;
            case (state_q)
                IDLE: if (cpu_addr == DMA_REG_ADDR && !cpu_r_nw) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
                HALT:  state_d = par_q ? READ : ALIGN;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = bus_din;
                    state_d = WRITE;
                end
                WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? IDLE : READ;
                    done_d  = (idx_q == 8'hFF);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end
    assign cpu_rdy  = (state_q == IDLE);
    assign bus_sel  = ~cpu_rdy;
    assign bus_addr = (state_q == READ) ? {page_q, idx_q} : (state_q == WRITE) ? OAM_DATA_ADDR : 16'h0000;
    assign bus_dout = (state_q == WRITE) ? data_q : 8'h00;
    assign bus_r_nw = (state_q != WRITE);
    assign dma_done = done_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench; a page-copy model queues the expected per-CPU-cycle bus ops.
module tb_oam_dma_ctrl;
    typedef struct packed {logic [15:0] a; logic [7:0] d; logic r;} op_t;
    logic        clk = 0, rst = 0, cpu_cycle_en = 0, cpu_r_nw = 1;
    logic [15:0] cpu_addr = 0;
    logic [7:0]  cpu_dout = 0, salt = 0;
    logic        cpu_rdy, bus_sel, bus_r_nw, dma_done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout, bus_din;
    int          checks = 0, failures = 0, done_seen = 0, done_exp = 0, busy_m = 0;
    bit          par_m = 0;
    op_t         exp_q[$];
    always #5 clk = ~clk;
    // memory behind the bus: low address byte ^ 5A ^ salt
    assign bus_din = bus_addr[7:0] ^ 8'h5A ^ salt;
    oam_dma_ctrl dut (
        .clk(clk), .rst(rst), .cpu_cycle_en(cpu_cycle_en), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .cpu_r_nw(cpu_r_nw), .cpu_rdy(cpu_rdy), .bus_sel(bus_sel),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_r_nw(bus_r_nw), .bus_din(bus_din),
        .dma_done(dma_done)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            chk("cpu_rdy", {31'd0, cpu_rdy}, {31'd0, busy_m == 0});
            chk("bus_sel", {31'd0, bus_sel}, {31'd0, busy_m != 0});
            if (busy_m != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL exp_queue actual=empty required=op t=%0t", $time);
                end else begin
                    if (exp_q[0].r) chk("bus_rd", {15'd0, bus_addr, bus_r_nw}, {15'd0, exp_q[0].a, 1'b1});
                    else chk("bus_wr", {7'd0, bus_addr, bus_dout, bus_r_nw}, {7'd0, exp_q[0]});
                    if (cpu_cycle_en) void'(exp_q.pop_front());
                end
            end else chk("bus_idle", {7'd0, bus_addr, bus_dout, bus_r_nw}, 32'h1);
        end
        if (dma_done) done_seen++;
    end
    task automatic start_dma(input logic [7:0] p);
        int halt = par_m ? 514 : 513;
        repeat (halt - 512) exp_q.push_back('{16'h0000, 8'h00, 1'b1});
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{{p, 8'(i)}, 8'h00, 1'b1});
            exp_q.push_back('{16'h2004, 8'(i) ^ 8'h5A ^ salt, 1'b0});
        end
        busy_m = halt;
    endtask
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        cpu_addr = a; cpu_dout = d; cpu_r_nw = rnw; cpu_cycle_en = 1;
        @(posedge clk); #1;
        cpu_cycle_en = 0;
        if (busy_m > 0) begin
            busy_m--;
            if (busy_m == 0) done_exp++;
        end else if (!rnw && a == 16'h4014) start_dma(d);
        par_m = ~par_m;
    endtask
    task automatic noise(input int n, input int gmin, input int gmax);
        for (int j = 0; j < n; j++) begin
            int k = $urandom_range(0, 3);
            logic [15:0] a = (k == 0 || k == 3) ? 16'h4014 : (k == 1) ? 16'h4015 : 16'($urandom);
            logic rnw = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : (k == 3) ? (busy_m == 0) : 1'($urandom);
            if (a == 16'h4014 && busy_m == 0) rnw = 1'b1;
            cpu_cycle(a, 8'($urandom), rnw, $urandom_range(gmin, gmax));
        end
    endtask
    task automatic trigger(input logic [7:0] p, input bit want_par, input int gmin, input int gmax);
        int lim = 0;
        if (par_m != want_par) noise(1, gmin, gmax);
        cpu_cycle(16'h4014, p, 1'b0, gmin);
        while (busy_m > 0 && lim < 600) begin
            noise(1, gmin, gmax);
            lim++;
        end
        @(negedge clk); #1;
        chk("done_count", done_seen, done_exp);
        @(posedge clk); #1;
    endtask
    task automatic reset_mid();
        if (par_m) noise(1, 0, 0);
        cpu_cycle(16'h4014, 8'h71, 1'b0, 0);
        noise(257, 0, 0);
        rst = 0; cpu_cycle_en = 1; cpu_addr = 16'h4014; cpu_r_nw = 0; cpu_dout = 8'h44;
        exp_q.delete(); busy_m = 0; par_m = 0;
        @(posedge clk); #1;
        rst = 1; cpu_cycle_en = 0;
        @(negedge clk); #1;
        chk("rst_mid_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_mid_sel", {31'd0, bus_sel}, 32'd0);
        chk("rst_mid_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_mid_done", done_seen, done_exp);
        @(posedge clk); #1;
    endtask
    initial begin
        cpu_cycle_en = 1; cpu_addr = 16'h4014; cpu_r_nw = 0; cpu_dout = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        cpu_cycle_en = 0;
        @(negedge clk);
        chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_sel", {31'd0, bus_sel}, 32'd0);
        chk("rst_bus", {7'd0, bus_addr, bus_dout, bus_r_nw}, 32'h1);
        chk("rst_done", {31'd0, dma_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1;
        noise(12, 0, 2);
        trigger(8'h02, 1'b0, 0, 0);
        trigger(8'h02, 1'b1, 0, 0);
        trigger(8'($urandom_range(8'h20, 8'h3F)), 1'($urandom), 11, 11);
        reset_mid();
        trigger(8'($urandom), 1'($urandom), 0, 1);
        trigger(8'hFF, 1'($urandom), 0, 3);
        for (int t = 0; t < 3; t++) begin
            salt = 8'($urandom);
            trigger(8'($urandom), 1'($urandom), 0, 2);
        end
        noise(5, 0, 1);
        chk("exp_q_left", exp_q.size(), 0);
        chk("done_final", done_seen, done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
